// File: rtl/gated_alu_bank.sv
// gated_alu_bank: a bank of CHANNELS load-enabled arithmetic result registers
// sharing operands d1/d2, each with its own load enable, op select, valid
// pulse and saturating activity counter.
// Optional macro GATED_ALU_BANK_FLAGS_EN adds a per-channel carry/borrow
// output cy, held alongside q and updated only when that channel loads.
module gated_alu_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int ACT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          d1,
    input  logic [WIDTH-1:0]          d2,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [2*CHANNELS-1:0]     op,
    input  logic                      clr_cnt,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       q_valid,
`ifdef GATED_ALU_BANK_FLAGS_EN
    output logic [CHANNELS-1:0]       cy,
`endif
    output logic [CHANNELS*ACT_W-1:0] act_cnt
);

`ifdef GATED_ALU_BANK_FLAGS_EN
    // One extra result bit carries the add carry-out or the subtract borrow.
    localparam int RES_W = WIDTH + 1;
`else
    localparam int RES_W = WIDTH;
`endif

    localparam logic [ACT_W-1:0] ACT_MAX = {ACT_W{1'b1}};

    logic [WIDTH-1:0] r_q     [CHANNELS];
    logic [ACT_W-1:0] r_cnt   [CHANNELS];
    logic [RES_W-1:0] w_res   [CHANNELS];
    logic             r_valid [CHANNELS];
`ifdef GATED_ALU_BANK_FLAGS_EN
    logic             r_cy    [CHANNELS];
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0] w_op;
        assign w_op = op[2*i +: 2];

        // Next result for this channel; zero-extended so the top bit is carry/borrow.
        always_comb begin
            w_res[i] = '0;
            case (w_op)
                2'b00:   w_res[i] = RES_W'(d1) + RES_W'(d2);
                2'b01:   w_res[i] = RES_W'(d2) - RES_W'(d1);
                2'b10:   w_res[i] = RES_W'(d1) - RES_W'(d2);
                default: w_res[i] = RES_W'(r_q[i]) + RES_W'(d1);
            endcase
        end

        // Result register: written only under reset or its load enable, so it gates cleanly.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_q[i] <= '0;
            end else if (ld[i]) begin
                r_q[i] <= w_res[i][WIDTH-1:0];
            end
        end

        // Valid pulse follows the load enable by one cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid[i] <= 1'b0;
            end else begin
                r_valid[i] <= ld[i];
            end
        end

        // Activity counter: clear beats a coincident load, and it sticks at all-ones.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[i] <= '0;
            end else if (clr_cnt) begin
                r_cnt[i] <= '0;
            end else if (ld[i] && (r_cnt[i] != ACT_MAX)) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end

`ifdef GATED_ALU_BANK_FLAGS_EN
        // Carry/borrow flag shares the result register's enable.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cy[i] <= 1'b0;
            end else if (ld[i]) begin
                r_cy[i] <= w_res[i][RES_W-1];
            end
        end

        assign cy[i] = r_cy[i];
`endif

        assign q[i*WIDTH +: WIDTH]       = r_q[i];
        assign act_cnt[i*ACT_W +: ACT_W] = r_cnt[i];
        assign q_valid[i]                = r_valid[i];
    end

endmodule

// File: tb/tb_gated_alu_bank.sv
// Self-checking bench for gated_alu_bank (WIDTH=8, CHANNELS=2, ACT_W=4).
// A reference model pushes expected outputs into a scoreboard queue when each
// step is driven; the queue is popped and compared one cycle later.
module tb_gated_alu_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int ACT_W    = 4;

    typedef struct packed {
        logic [15:0] q;
        logic [1:0]  v;
        logic [7:0]  cnt;
        logic [1:0]  cy;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [1:0]  ld;
    logic [3:0]  op;
    logic        clrCnt;
    logic [15:0] q;
    logic [1:0]  qValid;
    logic [7:0]  actCnt;
    logic [1:0]  cy;

    exp_t sbQ[$];

    int total;
    int bad;

    // Reference model state
    logic [7:0] mq  [2];
    logic [3:0] mcnt[2];
    logic       mcy [2];

    gated_alu_bank #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .ACT_W(ACT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .d1(d1),
        .d2(d2),
        .ld(ld),
        .op(op),
        .clr_cnt(clrCnt),
        .q(q),
        .q_valid(qValid),
`ifdef GATED_ALU_BANK_FLAGS_EN
        .cy(cy),
`endif
        .act_cnt(actCnt)
    );

`ifndef GATED_ALU_BANK_FLAGS_EN
    assign cy = 2'b00;
`endif

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one step, advance the model and push the expected outputs.
    task automatic applyStimulus(input logic rn, input logic [1:0] l, input logic [3:0] o,
                                 input logic [7:0] a, input logic [7:0] b, input logic clr);
        exp_t e;
        int   s;
        rst_n  = rn;
        ld     = l;
        op     = o;
        d1     = a;
        d2     = b;
        clrCnt = clr;
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                mq[i]   = 8'h00;
                mcnt[i] = 4'h0;
                mcy[i]  = 1'b0;
            end else begin
                if (l[i]) begin
                    case (o[2*i +: 2])
                        2'b00: begin s = int'(a) + int'(b);     mq[i] = s[7:0]; mcy[i] = (s > 255); end
                        2'b01: begin s = int'(b) - int'(a);     mq[i] = s[7:0]; mcy[i] = (b < a);   end
                        2'b10: begin s = int'(a) - int'(b);     mq[i] = s[7:0]; mcy[i] = (a < b);   end
                        default: begin s = int'(mq[i]) + int'(a); mq[i] = s[7:0]; mcy[i] = (s > 255); end
                    endcase
                end
                if (clr)                          mcnt[i] = 4'h0;
                else if (l[i] && mcnt[i] != 4'hF) mcnt[i] = mcnt[i] + 4'h1;
            end
        end
        e.q   = {mq[1], mq[0]};
        e.v   = rn ? l : 2'b00;
        e.cnt = {mcnt[1], mcnt[0]};
        e.cy  = {mcy[1], mcy[0]};
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Generic compare point used by scoreboard and directed checks.
    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare against the registered outputs.
    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sbQ.pop_front();
        checkValue("q", 32'(q), 32'(e.q));
        checkValue("q_valid", 32'(qValid), 32'(e.v));
        checkValue("act_cnt", 32'(actCnt), 32'(e.cnt));
`ifdef GATED_ALU_BANK_FLAGS_EN
        checkValue("cy", 32'(cy), 32'(e.cy));
`endif
    endtask

    logic [15:0] holdQ;
    logic [7:0]  holdCnt;
    logic [1:0]  holdCy;

    // Directed sequence following the plan, plus a few random dual-channel loads.
    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        ld     = 2'b00;
        op     = 4'h0;
        d1     = 8'h00;
        d2     = 8'h00;
        clrCnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mq[i] = 8'h00; mcnt[i] = 4'h0; mcy[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset for two cycles, with loads requested that must be ignored
        applyStimulus(1'b0, 2'b11, 4'h0, 8'h12, 8'h34, 1'b1);
        applyStimulus(1'b0, 2'b11, 4'h5, 8'h56, 8'h78, 1'b0);
        checkValue("reset_q", 32'(q), 32'h0);

        // Add on channel 0 only
        applyStimulus(1'b1, 2'b01, 4'b0000, 8'h10, 8'h05, 1'b0);
        checkValue("add_q0", 32'(q[7:0]), 32'h15);
        checkValue("add_q1", 32'(q[15:8]), 32'h00);
        checkValue("add_valid", 32'(qValid), 32'h1);
        checkValue("add_cnt", 32'(actCnt), 32'h01);
        applyStimulus(1'b1, 2'b00, 4'b0000, 8'h77, 8'h66, 1'b0);
        checkValue("valid_pulse_end", 32'(qValid), 32'h0);

        // Subtract with borrow on channel 1 (d2 - d1)
        applyStimulus(1'b1, 2'b10, 4'b0100, 8'h05, 8'h03, 1'b0);
        checkValue("sub_q1", 32'(q[15:8]), 32'hFE);
        checkValue("sub_q0_held", 32'(q[7:0]), 32'h15);
`ifdef GATED_ALU_BANK_FLAGS_EN
        checkValue("sub_cy1", 32'(cy[1]), 32'h1);
`endif

        // Channel 1 d1 - d2 without borrow
        applyStimulus(1'b1, 2'b10, 4'b1000, 8'h09, 8'h04, 1'b0);
        checkValue("sub2_q1", 32'(q[15:8]), 32'h05);

        // Accumulate wrap on channel 0
        applyStimulus(1'b1, 2'b01, 4'b0000, 8'hF0, 8'h00, 1'b0);
        applyStimulus(1'b1, 2'b01, 4'b0011, 8'h20, 8'h99, 1'b0);
        checkValue("acc_q0", 32'(q[7:0]), 32'h10);
`ifdef GATED_ALU_BANK_FLAGS_EN
        checkValue("acc_cy0", 32'(cy[0]), 32'h1);
`endif

        // Hold: no loads while operands and ops churn
        holdQ   = q;
        holdCnt = actCnt;
        holdCy  = cy;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 2'b00, 4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            checkValue("hold_q", 32'(q), 32'(holdQ));
            checkValue("hold_cnt", 32'(actCnt), 32'(holdCnt));
            checkValue("hold_cy", 32'(cy), 32'(holdCy));
        end

        // Both channels loading together with random ops
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'b11, 4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end

        // Saturate channel 0 counter with 20 consecutive loads
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 2'b01, 4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end
        checkValue("sat_cnt0", 32'(actCnt[3:0]), 32'hF);

        // Clear wins over a coincident load; q0 still loads
        applyStimulus(1'b1, 2'b01, 4'b0000, 8'h21, 8'h43, 1'b0 | 1'b1);
        checkValue("clr_cnt", 32'(actCnt), 32'h00);
        checkValue("clr_q0", 32'(q[7:0]), 32'h64);

        // Reset mid-operation with loads requested
        applyStimulus(1'b1, 2'b11, 4'b0000, 8'h01, 8'h02, 1'b0);
        applyStimulus(1'b0, 2'b11, 4'b0000, 8'hAA, 8'h55, 1'b0);
        checkValue("rst_mid_q", 32'(q), 32'h0);
        checkValue("rst_mid_valid", 32'(qValid), 32'h0);
        checkValue("rst_mid_cnt", 32'(actCnt), 32'h0);
        checkValue("rst_mid_cy", 32'(cy), 32'h0);

        // Recovery after reset
        applyStimulus(1'b1, 2'b11, 4'b0110, 8'h30, 8'h10, 1'b0);
        checkValue("post_rst_q", 32'(q), 32'hE020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
